// File: rtl/program_counter_stack.sv
// -----------------------------------------------------------------------------
// program_counter_stack
//
// Program counter for the BIP core with a small return-address stack (LIFO).
// It drives the instruction-memory address bus and supports sequential
// increment, absolute jump, stall, and subroutine call/return.
//
// Request priority each cycle, highest first:
//   stall > ret > call > jump > en > hold
// Lower-priority requests that arrive with a winning one are dropped.
//
// Parameters:
//   ADDR_W      width of the address bus / PC register
//   STACK_DEPTH number of return-address entries (>= 1)
//   RESET_ADDR  PC value loaded on reset
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           advance PC by one
//   stall        hold PC and stack; overrides every other request
//   jump         load jump_addr into PC
//   call         push PC+1 and load jump_addr into PC
//   ret          pop top of stack into PC
//   jump_addr    target for jump/call
//   address_bus  current PC (registered)
//   stack_empty  no entries on the stack
//   stack_full   STACK_DEPTH entries on the stack
//   stack_err    sticky: push on full or pop on empty occurred
//   halted       (PC_WRAP_HALT_EN only) PC stopped at all-ones
//   wrap         one-cycle pulse when an increment leaves the all-ones PC
//
// Optional feature (macro PC_WRAP_HALT_EN):
//   Defined   - an increment from all-ones holds the PC at all-ones, pulses
//               wrap once and latches halted. While halted, every request is
//               ignored until reset.
//   Undefined - the PC wraps to zero together with the wrap pulse.
// -----------------------------------------------------------------------------
module program_counter_stack #(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] address_bus,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err,
`ifdef PC_WRAP_HALT_EN
    output logic              halted,
`endif
    output logic              wrap
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    // Increment with the carry kept, so the caller can see the all-ones case.
    function automatic logic [ADDR_W:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
    endfunction

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    logic [ADDR_W:0]   inc_full;
    logic [ADDR_W-1:0] pc_plus1;
    logic              inc_carry;

    logic [ADDR_W-1:0] pc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              err_nxt;
    logic              wrap_nxt;
    logic              push;
    logic              busy_halt;
`ifdef PC_WRAP_HALT_EN
    logic              halt_nxt;
`endif

    assign stack_empty = (count == '0);
    assign stack_full  = (count == FULL_CNT);

    // Slicing is safe: push_idx is only used when not full, pop_idx only
    // when not empty, so both stay inside 0..STACK_DEPTH-1.
    assign cnt_dec  = count - CNT_W'(1);
    assign push_idx = count[IDX_W-1:0];
    assign pop_idx  = cnt_dec[IDX_W-1:0];

    assign inc_full  = pc_incr(address_bus);
    assign pc_plus1  = inc_full[ADDR_W-1:0];
    assign inc_carry = inc_full[ADDR_W];

`ifdef PC_WRAP_HALT_EN
    assign busy_halt = halted;
`else
    assign busy_halt = 1'b0;
`endif

    // ---- request decode: choose next PC / stack state ----
    always_comb begin
        pc_nxt   = address_bus;
        cnt_nxt  = count;
        err_nxt  = stack_err;
        wrap_nxt = 1'b0;
        push     = 1'b0;
`ifdef PC_WRAP_HALT_EN
        halt_nxt = halted;
`endif
        if (stall || busy_halt) begin
            // hold everything
        end else if (ret) begin
            if (!stack_empty) begin
                pc_nxt  = stack_mem[pop_idx];
                cnt_nxt = cnt_dec;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (call) begin
            if (!stack_full) begin
                push    = 1'b1;
                cnt_nxt = count + CNT_W'(1);
                pc_nxt  = jump_addr;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (jump) begin
            pc_nxt = jump_addr;
        end else if (en) begin
            wrap_nxt = inc_carry;
`ifdef PC_WRAP_HALT_EN
            if (inc_carry) begin
                halt_nxt = 1'b1;
            end else begin
                pc_nxt = pc_plus1;
            end
`else
            pc_nxt = pc_plus1;
`endif
        end
    end

    // ---- register stage: control state with async reset ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_bus <= RESET_ADDR;
            count       <= '0;
            stack_err   <= 1'b0;
            wrap        <= 1'b0;
`ifdef PC_WRAP_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            address_bus <= pc_nxt;
            count       <= cnt_nxt;
            stack_err   <= err_nxt;
            wrap        <= wrap_nxt;
`ifdef PC_WRAP_HALT_EN
            halted      <= halt_nxt;
`endif
        end
    end

    // ---- return-address storage: data only, contents undefined after reset ----
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the BIP program counter.
- Drives the instruction-memory address bus.
- Supports sequential increment, absolute jump, stall, and subroutine call/return through a small hardware return-address stack (LIFO).
- Sits between the BIP control unit (which decodes jump/call/ret) and program memory.

Parameters:
- ADDR_W, 11, width of the address bus / PC register.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, PC value loaded on reset (ADDR_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance PC this cycle.
- stall  input  1  hold PC and stack this cycle; overrides all other requests.
- jump  input  1  load jump_addr into PC.
- call  input  1  push PC+1 and load jump_addr.
- ret  input  1  pop top of stack into PC.
- jump_addr  input  ADDR_W  target for jump/call.
- address_bus  output  ADDR_W  current PC, registered.
- stack_empty  output  1  no entries on stack.
- stack_full  output  1  STACK_DEPTH entries on stack.
- stack_err  output  1  sticky: push on full or pop on empty occurred.
- wrap  output  1  one-cycle pulse: increment passed from 2^ADDR_W-1 to 0.

Behaviour:
- Reset (async assert, sync release by design):
  - address_bus=RESET_ADDR, stack count=0, stack_empty=1, stack_full=0, stack_err=0, wrap=0, halted=0.
  - Stack entry contents are don't-care.
- All updates occur on the rising clk edge. Outputs are registered; a request sampled at edge N is visible after edge N.
- Per-cycle priority, highest first: stall > ret > call > jump > en > hold.
  - stall=1: PC, stack, count unchanged. wrap=0.
  - ret=1, stack not empty: PC <= stack[top]; count-1.
  - ret=1, stack empty: PC unchanged; stack_err<=1.
  - call=1, stack not full: stack[count] <= PC+1 (mod 2^ADDR_W); count+1; PC <= jump_addr.
  - call=1, stack full: PC unchanged, no push; stack_err<=1.
  - jump=1: PC <= jump_addr; stack unchanged.
  - en=1: PC <= PC+1 mod 2^ADDR_W. wrap=1 for that cycle if old PC = all ones (see optional feature).
  - Otherwise hold.
- Lower-priority requests asserted together with a winning one are dropped, not queued.
- Simultaneous call+ret: ret wins; no push occurs.
- Flag derivation: stack_empty = (count==0); stack_full = (count==STACK_DEPTH). Both are derived from the registered count.
- stack_err is cleared only by reset.
- Counter width: count is clog2(STACK_DEPTH+1) bits. All PC arithmetic is ADDR_W bits, unsigned, modulo.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro PC_WRAP_HALT_EN.
- Defined:
  - An increment from all-ones does not wrap. PC holds at all-ones; wrap pulses once.
  - Internal halted latches to 1. While halted, en and jump are ignored; ret and call are still ignored.
  - Only reset clears halted.
  - Extra output halted (1 bit, reset 0) is present.
- Undefined:
  - PC wraps to 0 with the wrap pulse; no halted port or logic.

Test Plan:
- Reset: rst_n=0 mid-cycle with PC=0x123 -> address_bus=0 immediately, stack_empty=1, stack_err=0.
- Increment: en=1 for 5 cycles from reset -> address_bus 1,2,3,4,5; hold en=0 -> stays 5. Then stall=1 with en=1 -> stays 5.
- Call/return: PC=0x010, call with jump_addr=0x200 -> PC=0x200, stack_empty=0. en x3 -> 0x203. ret -> PC=0x011, stack_empty=1.
- Stack limits (STACK_DEPTH=4):
  - 4 nested calls -> stack_full=1. 5th call -> PC unchanged, stack_err=1.
  - 4 rets unwind in LIFO order. A 5th ret -> PC unchanged, stack_err stays 1.
- Priority: ret+call+jump+en together with stack holding 0x055 -> PC=0x055, no push. stall+ret -> no change.
- Wrap (ADDR_W=11): jump to 0x7FF, en -> without macro PC=0x000 and wrap pulses 1 cycle. With PC_WRAP_HALT_EN, PC stays 0x7FF, halted=1, and a later jump to 0x100 is ignored.
